// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge channel between the fetch stage and imem.
interface fetch_stage_if;
    logic        req;
    logic [15:0] adr;
    logic        ack;
    logic [15:0] rdata;

    modport master (output req, output adr, input ack, input rdata);
    modport slave  (input req, input adr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// buffers fetched words in a small queue and drives the IF/ID register.
module fetch_stage #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_pc,
    input  logic          halt_fetch,
    input  logic          en_ifid,
    input  logic          flush_ifid,
    input  logic          jump_pred,
    input  logic [15:0]   jump_pred_adr,
    input  logic          jump_pred_miss,
    input  logic [15:0]   pcinc_evac,
    input  logic          jump_pred_adr_miss,
    input  logic [15:0]   jump_target_ex,
    fetch_stage_if.master imem,
    output logic [15:0]   inst_id,
    output logic [15:0]   pcinc_id,
    output logic          flushed
);
    localparam int unsigned AW = 16;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          drop_q, drop_d;
    logic          req_q, req_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [AW-1:0] q_inst_q [DEPTH];
    logic [AW-1:0] q_inst_d [DEPTH];
    logic [AW-1:0] q_pcinc_q [DEPTH];
    logic [AW-1:0] q_pcinc_d [DEPTH];
    logic [AW-1:0] inst_d, pcinc_d;
    logic          flushed_d;

    logic          redirect;
    logic [AW-1:0] target;
    logic          ack_hit;
    logic          outstanding;
    logic          accept;
    logic          load;
    logic          deq;
    logic          bypass;
    logic          enq;
    logic [AW-1:0] acc_pcinc;
    logic [CW-1:0] wr_idx;

    assign imem.req = req_q;
    assign imem.adr = adr_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            req_q    <= 1'b0;
            adr_q    <= RESET_PC;
            inst_id  <= '0;
            pcinc_id <= '0;
            flushed  <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_inst_q[i]  <= '0;
                q_pcinc_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            req_q     <= req_d;
            adr_q     <= adr_d;
            inst_id   <= inst_d;
            pcinc_id  <= pcinc_d;
            flushed   <= flushed_d;
            q_inst_q  <= q_inst_d;
            q_pcinc_q <= q_pcinc_d;
        end
    end

    // Next-state: redirect, handshake, queue and IF/ID
    always_comb begin
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        req_d     = req_q;
        adr_d     = adr_q;
        inst_d    = inst_id;
        pcinc_d   = pcinc_id;
        flushed_d = flushed;
        q_inst_d  = q_inst_q;
        q_pcinc_d = q_pcinc_q;

        redirect = 1'b1;
        target   = pc_q;
        if (jump_pred_miss) begin
            target = pcinc_evac;
        end else if (jump_pred_adr_miss) begin
            target = jump_target_ex;
        end else if (jump_pred) begin
            target = jump_pred_adr;
        end else begin
            redirect = 1'b0;
        end

        ack_hit     = req_q && imem.ack;
        outstanding = req_q && !imem.ack;
        accept      = ack_hit && !drop_q && !redirect;
        acc_pcinc   = adr_q + AW'(1);

        // Bypass only into an empty queue, so FIFO order is never overtaken
        load   = en_ifid && !flush_ifid;
        deq    = load && (cnt_q != '0) && !redirect;
        bypass = load && (cnt_q == '0) && accept;
        enq    = accept && !bypass;
        wr_idx = cnt_q - CW'(deq);

        if (ack_hit) begin
            drop_d = 1'b0;
        end
        if (redirect && outstanding) begin
            drop_d = 1'b1;
        end

        if (redirect) begin
            pc_d = target;
        end else if (accept) begin
            pc_d = acc_pcinc;
        end

        if (deq) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                q_inst_d[i]  = q_inst_q[i+1];
                q_pcinc_d[i] = q_pcinc_q[i+1];
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (enq && (CW'(i) == wr_idx)) begin
                q_inst_d[i]  = imem.rdata;
                q_pcinc_d[i] = acc_pcinc;
            end
        end

        if (redirect) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(enq) - CW'(deq);
        end

        if (en_ifid) begin
            if (deq) begin
                inst_d    = q_inst_q[0];
                pcinc_d   = q_pcinc_q[0];
                flushed_d = 1'b0;
            end else if (bypass) begin
                inst_d    = imem.rdata;
                pcinc_d   = acc_pcinc;
                flushed_d = 1'b0;
            end else begin
                inst_d    = '0;
                pcinc_d   = '0;
                flushed_d = 1'b1;
            end
        end

        // An outstanding request holds req/adr until acknowledged
        if (!outstanding) begin
            req_d = !drop_d && en_pc && !halt_fetch && (cnt_d < DEPTH_C);
            adr_d = pc_d;
        end
    end
endmodule
